// File: rtl/vec_delta_recon.sv
// Per-lane delta decoder: rebuilds vectors from a frame base plus running differences.
// One-cycle latency, single output register with ready/valid backpressure.
module vec_delta_recon #(
    parameter int unsigned DIMENSION = 16,
    parameter int unsigned WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_first,
    input  logic [DIMENSION*WIDTH-1:0] in_diff,
    input  logic [DIMENSION*WIDTH-1:0] in_base,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIMENSION*WIDTH-1:0] out_data,
    output logic                       out_first,
    output logic [15:0]                vec_count
);

    localparam int unsigned VW = DIMENSION * WIDTH;
    localparam int unsigned CW = 16;

    logic [VW-1:0] acc;
    logic [VW-1:0] sum_c;
    logic          in_xfer_c;

    // Accept only when the output register is free or draining this cycle.
    always_comb begin
        in_ready  = en & (~out_valid | out_ready) & ~rst;
        in_xfer_c = in_valid & in_ready;
    end

    // Lane-wise modulo add; no carry crosses a lane boundary.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < DIMENSION; i++) begin
            sum_c[i*WIDTH +: WIDTH] = (in_first ? in_base[i*WIDTH +: WIDTH]
                                                : acc[i*WIDTH +: WIDTH])
                                      + in_diff[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            vec_count <= '0;
        end else if (in_xfer_c) begin
            acc       <= sum_c;
            out_valid <= 1'b1;
            out_data  <= sum_c;
            out_first <= in_first;
            vec_count <= in_first ? CW'(1) : vec_count + CW'(1);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_delta_recon.sv
// Directed plus randomized round-trip checks for vec_delta_recon.
module tb_vec_delta_recon;

    localparam int unsigned D  = 16;
    localparam int unsigned W  = 8;
    localparam int unsigned VW = D * W;
    localparam int unsigned NV = 64;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, in_ready, in_first, out_valid, out_ready, out_first;
    logic [VW-1:0] in_diff, in_base, out_data;
    logic [15:0]   vec_count;

    int n_assert = 0;
    int n_fail   = 0;

    vec_delta_recon #(.DIMENSION(D), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_diff(in_diff), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_first(out_first), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [W-1:0] b);
        logic [VW-1:0] r;
        for (int l = 0; l < D; l++) r[l*W +: W] = b;
        return r;
    endfunction

    function automatic logic [VW-1:0] add_k(input logic [VW-1:0] v, input int k);
        logic [VW-1:0] r;
        for (int l = 0; l < D; l++) r[l*W +: W] = W'(int'(v[l*W +: W]) + k);
        return r;
    endfunction

    // Encoder side of the round trip: per-lane (a - b) mod 2^W.
    function automatic logic [VW-1:0] sub_v(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int l = 0; l < D; l++) r[l*W +: W] = W'(a[l*W +: W] - b[l*W +: W]);
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_v();
        logic [VW-1:0] r;
        for (int j = 0; j < VW / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input logic v, input logic f, input logic [VW-1:0] d,
                         input logic [VW-1:0] b, input logic ordy, input logic e);
        in_valid  = v;
        in_first  = f;
        in_diff   = d;
        in_base   = b;
        out_ready = ordy;
        en        = e;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [VW-1:0] v0, v1, r_exp, orig[NV], diffs[NV], bases[NV], prev;
    logic [VW-1:0] q_data[$];
    logic [15:0]   q_cnt[$];
    logic          q_first[$];
    logic          frst[NV];
    logic          exp_ov, exp_ir;
    logic [15:0]   mcnt;
    int            idx, got, cycles;

    initial begin
        // Reset dominates active inputs.
        rst = 1'b1;
        drive(1'b1, 1'b1, fill(8'h33), fill(8'h44), 1'b1, 1'b1);
        cyc(); cyc();
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_vec_count", vec_count, 0);

        // Frame start: 0x10 + 0x05.
        cyc();
        rst = 1'b0;
        drive(1'b1, 1'b1, fill(8'h05), fill(8'h10), 1'b1, 1'b1);
        #1 chk("fs_in_ready", in_ready, 1);
        cyc();
        chk("fs_out_valid", out_valid, 1);
        chk("fs_out_data", out_data, fill(8'h15));
        chk("fs_out_first", out_first, 1);
        chk("fs_vec_count", vec_count, 1);

        // Lane wrap without cross-lane carry.
        v0 = '0; v0[0 +: W] = 8'hFE; v0[W +: W] = 8'h20;
        drive(1'b1, 1'b1, v0, '0, 1'b1, 1'b1);
        cyc();
        chk("wrap_first_data", out_data, v0);
        v1 = '0; v1[0 +: W] = 8'h03; v1[2*W +: W] = 8'hFF;
        drive(1'b1, 1'b0, v1, rnd_v(), 1'b1, 1'b1);
        cyc();
        r_exp = '0; r_exp[0 +: W] = 8'h01; r_exp[W +: W] = 8'h20; r_exp[2*W +: W] = 8'hFF;
        chk("wrap_data", out_data, r_exp);
        chk("wrap_out_first", out_first, 0);
        chk("wrap_vec_count", vec_count, 2);

        // Backpressure: one accept, then three stalled cycles.
        drive(1'b1, 1'b0, fill(8'h01), '0, 1'b1, 1'b1);
        #1 chk("bp_in_ready_a", in_ready, 1);
        cyc();
        chk("bp_data_a", out_data, add_k(r_exp, 1));
        for (int s = 0; s < 3; s++) begin
            drive(1'b1, 1'b0, fill(8'h01), '0, 1'b0, 1'b1);
            #1 chk("bp_in_ready_stall", in_ready, 0);
            cyc();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, add_k(r_exp, 1));
            chk("bp_hold_count", vec_count, 3);
        end
        drive(1'b1, 1'b0, fill(8'h01), '0, 1'b1, 1'b1);
        #1 chk("bp_in_ready_resume", in_ready, 1);
        cyc();
        chk("bp_data_c", out_data, add_k(r_exp, 2));
        chk("bp_count_c", vec_count, 4);
        #1 chk("bp_in_ready_d", in_ready, 1);
        cyc();
        chk("bp_data_d", out_data, add_k(r_exp, 3));
        chk("bp_count_d", vec_count, 5);

        // en low drains the output and blocks input.
        drive(1'b1, 1'b0, fill(8'h01), '0, 1'b1, 1'b0);
        #1 chk("en_in_ready", in_ready, 0);
        cyc();
        chk("en_drain_valid", out_valid, 0);
        chk("en_count", vec_count, 5);
        cyc();
        chk("en_still_idle", out_valid, 0);

        // Reset mid-frame with an output pending.
        drive(1'b1, 1'b0, fill(8'h01), '0, 1'b0, 1'b1);
        cyc();
        chk("mr_pending", out_valid, 1);
        rst = 1'b1;
        #1 chk("mr_in_ready", in_ready, 0);
        cyc();
        chk("mr_out_valid", out_valid, 0);
        chk("mr_out_data", out_data, 0);
        rst = 1'b0;
        drive(1'b1, 1'b0, fill(8'h07), rnd_v(), 1'b1, 1'b1);
        cyc();
        chk("mr_data", out_data, fill(8'h07));
        chk("mr_count", vec_count, 1);
        chk("mr_out_first", out_first, 0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        cyc();
        chk("mr_drained", out_valid, 0);

        // Random round trip with three frames and random handshakes.
        prev = '0;
        for (int i = 0; i < NV; i++) begin
            frst[i]  = (i == 0 || i == 23 || i == 47);
            orig[i]  = rnd_v();
            bases[i] = rnd_v();
            diffs[i] = frst[i] ? sub_v(orig[i], bases[i]) : sub_v(orig[i], prev);
            prev     = orig[i];
        end
        idx = 0; got = 0; cycles = 0; exp_ov = 1'b0; mcnt = '0;
        while (got < NV && cycles < 2000) begin
            chk("rt_out_valid", out_valid, exp_ov);
            if (exp_ov && q_data.size() > 0) begin
                chk("rt_out_data", out_data, q_data[0]);
                chk("rt_out_first", out_first, q_first[0]);
                chk("rt_vec_count", vec_count, q_cnt[0]);
            end
            in_valid  = (idx < NV) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            if (idx < NV) begin
                in_first = frst[idx];
                in_diff  = diffs[idx];
                in_base  = frst[idx] ? bases[idx] : rnd_v();
            end else begin
                in_first = 1'($urandom);
                in_diff  = rnd_v();
                in_base  = rnd_v();
            end
            exp_ir = en && (!exp_ov || out_ready);
            #1 chk("rt_in_ready", in_ready, exp_ir);
            if (exp_ov && out_ready) begin
                void'(q_data.pop_front());
                void'(q_first.pop_front());
                void'(q_cnt.pop_front());
                got++;
                exp_ov = 1'b0;
            end
            if (in_valid && exp_ir) begin
                mcnt = frst[idx] ? 16'd1 : mcnt + 16'd1;
                q_data.push_back(orig[idx]);
                q_first.push_back(frst[idx]);
                q_cnt.push_back(mcnt);
                idx++;
                exp_ov = 1'b1;
            end
            cyc();
            cycles++;
        end
        chk("rt_outputs_received", got, NV);

        // vec_count wraps from 65535 to 0.
        drive(1'b1, 1'b1, '0, '0, 1'b1, 1'b1);
        cyc();
        chk("wrap_cnt_start", vec_count, 1);
        in_first = 1'b0;
        repeat (65534) cyc();
        chk("wrap_cnt_max", vec_count, 16'hFFFF);
        cyc();
        chk("wrap_cnt_zero", vec_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
